// File: rtl/exe.sv
// RV32 execute stage: single-cycle integer ALU plus an iterative M-extension unit.
// The M unit stalls upstream via hold_o for 33 cycles, then presents its result for one cycle.
module exe #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned RADDR_WIDTH = 5,
    parameter int unsigned ADDR_WIDTH  = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [DATA_WIDTH-1:0]  op1_i,
    input  logic [DATA_WIDTH-1:0]  op2_i,
    input  logic                   reg_we_i,
    input  logic [RADDR_WIDTH-1:0] reg_waddr_i,
    input  logic [DATA_WIDTH-1:0]  inst_i,
    input  logic [ADDR_WIDTH-1:0]  inst_addr_i,
    input  logic                   flush_i,
    output logic [DATA_WIDTH-1:0]  reg_wdata_o,
    output logic                   reg_we_o,
    output logic [RADDR_WIDTH-1:0] reg_waddr_o,
    output logic [ADDR_WIDTH-1:0]  inst_addr_o,
    output logic                   hold_o
);

    localparam int unsigned CntW = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e                  r_state, w_state_next;
    logic [CntW-1:0]         r_cnt;
    logic [DATA_WIDTH-1:0]   r_op1, r_op2;
    logic [2*DATA_WIDTH-1:0] r_acc;
    logic [2:0]              r_f3;
    logic                    r_neg, r_neg_rem, r_div0;

    logic [6:0]            w_opcode;
    logic [2:0]            w_f3;
    logic                  w_is_imm, w_is_reg, w_is_m, w_is_op, w_is_lui, w_is_alu;
    logic [CntW-1:0]       w_shamt;
    logic [DATA_WIDTH-1:0] w_alu, w_sra;
    logic                  w_unused;

    assign w_opcode = inst_i[6:0];
    assign w_f3     = inst_i[14:12];
    assign w_is_imm = (w_opcode == 7'h13);
    assign w_is_reg = (w_opcode == 7'h33);
    assign w_is_m   = w_is_reg && (inst_i[31:25] == 7'h01);
    assign w_is_op  = w_is_reg && !w_is_m;
    assign w_is_lui = (w_opcode == 7'h37);
    assign w_is_alu = w_is_imm || w_is_op || w_is_lui;
    assign w_shamt  = op2_i[CntW-1:0];
    assign w_sra    = $signed(op1_i) >>> w_shamt;
    assign w_unused = ^{inst_i[24:15], inst_i[11:7]};

    always_comb begin
        w_alu = '0;
        if (w_is_lui) begin
            // funct3 bits belong to the LUI immediate, so force ADD
            w_alu = op1_i + op2_i;
        end else begin
            case (w_f3)
                3'b000:  w_alu = (w_is_op && inst_i[30]) ? op1_i - op2_i : op1_i + op2_i;
                3'b001:  w_alu = op1_i << w_shamt;
                3'b010:  w_alu = {{(DATA_WIDTH-1){1'b0}}, $signed(op1_i) < $signed(op2_i)};
                3'b011:  w_alu = {{(DATA_WIDTH-1){1'b0}}, op1_i < op2_i};
                3'b100:  w_alu = op1_i ^ op2_i;
                3'b101:  w_alu = inst_i[30] ? w_sra : op1_i >> w_shamt;
                3'b110:  w_alu = op1_i | op2_i;
                default: w_alu = op1_i & op2_i;
            endcase
        end
    end

    // Operand signedness per M funct3: op1 signed except *U; op2 signed for MUL/MULH/DIV/REM.
    logic                  w_s1, w_s2, w_neg1, w_neg2;
    logic [DATA_WIDTH-1:0] w_abs1, w_abs2;

    assign w_s1   = (w_f3 != 3'b011) && (w_f3 != 3'b101) && (w_f3 != 3'b111);
    assign w_s2   = w_s1 && (w_f3 != 3'b010);
    assign w_neg1 = w_s1 && op1_i[DATA_WIDTH-1];
    assign w_neg2 = w_s2 && op2_i[DATA_WIDTH-1];
    assign w_abs1 = w_neg1 ? -op1_i : op1_i;
    assign w_abs2 = w_neg2 ? -op2_i : op2_i;

    logic [DATA_WIDTH:0]   w_sum;
    logic [DATA_WIDTH:0]   w_shift;
    logic [DATA_WIDTH+1:0] w_diff;

    assign w_sum   = {1'b0, r_acc[2*DATA_WIDTH-1:DATA_WIDTH]}
                   + (r_op2[0] ? {1'b0, r_op1} : {(DATA_WIDTH+1){1'b0}});
    assign w_shift = {r_acc[DATA_WIDTH-1:0], r_op1[DATA_WIDTH-1]};
    assign w_diff  = {1'b0, w_shift} - {2'b00, r_op2};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= StIdle;
            r_cnt     <= '0;
            r_op1     <= '0;
            r_op2     <= '0;
            r_acc     <= '0;
            r_f3      <= '0;
            r_neg     <= 1'b0;
            r_neg_rem <= 1'b0;
            r_div0    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state == StIdle && w_state_next == StBusy) begin
                r_op1     <= w_abs1;
                r_op2     <= w_abs2;
                r_acc     <= '0;
                r_cnt     <= '0;
                r_f3      <= w_f3;
                r_neg     <= w_neg1 ^ w_neg2;
                r_neg_rem <= w_neg1;
                r_div0    <= (op2_i == '0);
            end else if (r_state == StBusy) begin
                r_cnt <= r_cnt + 1'b1;
                if (!r_f3[2]) begin
                    // Shift-add: product builds in r_acc, multiplier bits consumed from r_op2
                    r_acc <= {w_sum, r_acc[DATA_WIDTH-1:1]};
                    r_op2 <= r_op2 >> 1;
                end else if (!w_diff[DATA_WIDTH+1]) begin
                    // Restoring divide: r_acc low half is the remainder, r_op1 collects quotient
                    r_acc[DATA_WIDTH-1:0] <= w_diff[DATA_WIDTH-1:0];
                    r_op1 <= {r_op1[DATA_WIDTH-2:0], 1'b1};
                end else begin
                    r_acc[DATA_WIDTH-1:0] <= w_shift[DATA_WIDTH-1:0];
                    r_op1 <= {r_op1[DATA_WIDTH-2:0], 1'b0};
                end
            end
        end
    end

    logic [2*DATA_WIDTH-1:0] w_prod;
    logic [DATA_WIDTH-1:0]   w_quo, w_rem, w_mres;

    assign w_prod = r_neg ? -r_acc : r_acc;
    assign w_quo  = r_div0 ? '1 : (r_neg ? -r_op1 : r_op1);
    assign w_rem  = r_neg_rem ? -r_acc[DATA_WIDTH-1:0] : r_acc[DATA_WIDTH-1:0];

    always_comb begin
        case (r_f3)
            3'b000:          w_mres = w_prod[DATA_WIDTH-1:0];
            3'b001, 3'b010,
            3'b011:          w_mres = w_prod[2*DATA_WIDTH-1:DATA_WIDTH];
            3'b100, 3'b101:  w_mres = w_quo;
            default:         w_mres = w_rem;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        reg_wdata_o  = '0;
        reg_we_o     = 1'b0;
        hold_o       = 1'b0;
        case (r_state)
            StIdle: begin
                if (w_is_m) begin
                    if (!flush_i) begin
                        hold_o       = 1'b1;
                        w_state_next = StBusy;
                    end
                end else if (w_is_alu) begin
                    reg_wdata_o = w_alu;
                    reg_we_o    = reg_we_i;
                end
            end
            StBusy: begin
                hold_o = 1'b1;
                if (r_cnt == CntW'(DATA_WIDTH - 1)) begin
                    w_state_next = StDone;
                end
            end
            default: begin
                reg_wdata_o  = w_mres;
                reg_we_o     = reg_we_i;
                w_state_next = StIdle;
            end
        endcase
        if (flush_i) begin
            w_state_next = StIdle;
            hold_o       = 1'b0;
            reg_we_o     = 1'b0;
        end
        if (rst_i) begin
            reg_wdata_o = '0;
            reg_we_o    = 1'b0;
            hold_o      = 1'b0;
        end
    end

    assign reg_waddr_o = rst_i ? '0 : reg_waddr_i;
    assign inst_addr_o = rst_i ? '0 : inst_addr_i;

endmodule

// File: tb/tb_exe.sv
// Self-checking bench for exe: table-driven ALU vectors, M-unit latency/result runs,
// and hand-written flush and async-reset sequences, compared through a scoreboard queue.
module tb_exe;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] op1, op2, inst, inst_addr;
    logic        reg_we, flush;
    logic [4:0]  reg_waddr;
    logic [31:0] reg_wdata_o, inst_addr_o;
    logic        reg_we_o, hold_o;
    logic [4:0]  reg_waddr_o;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] wdata;
        logic        we;
        logic        hold;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic [31:0] inst;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] wdata;
        logic        we;
    } alu_vec_t;

    typedef struct {
        string       name;
        logic [31:0] inst;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] res;
    } m_vec_t;

    alu_vec_t alu_tab[14];
    m_vec_t   m_tab[12];

    exe dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .op1_i       (op1),
        .op2_i       (op2),
        .reg_we_i    (reg_we),
        .reg_waddr_i (reg_waddr),
        .inst_i      (inst),
        .inst_addr_i (inst_addr),
        .flush_i     (flush),
        .reg_wdata_o (reg_wdata_o),
        .reg_we_o    (reg_we_o),
        .reg_waddr_o (reg_waddr_o),
        .inst_addr_o (inst_addr_o),
        .hold_o      (hold_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc(input logic [6:0] f7, input logic [2:0] f3,
                                        input logic [6:0] opc);
        return {f7, 5'd2, 5'd1, f3, 5'd3, opc};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #1;
        inst = i;
        op1  = a;
        op2  = b;
    endtask

    task automatic check_out(input string name);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: got empty scoreboard expected an entry", name);
        end else begin
            e = exp_q.pop_front();
            check(name, {30'd0, reg_wdata_o, reg_we_o, hold_o}, {30'd0, e.wdata, e.we, e.hold});
        end
    endtask

    task automatic run_m(input m_vec_t v);
        int hcnt;
        apply(v.inst, v.op1, v.op2);
        exp_q.push_back('{v.res, 1'b1, 1'b0});
        hcnt = 0;
        for (int k = 0; k < 33; k++) begin
            @(negedge clk);
            if (hold_o && !reg_we_o) hcnt++;
        end
        check({v.name, " hold"}, 64'(hcnt), 64'd33);
        @(negedge clk);
        check_out(v.name);
    endtask

    initial begin
        int hcnt;
        alu_tab[0]  = '{enc(7'h7F, 3'b000, 7'h13), 32'h5,        32'hFFFFFFFD, 32'h2,        1'b1};
        alu_tab[1]  = '{enc(7'h20, 3'b101, 7'h33), 32'h80000000, 32'h4,        32'hF8000000, 1'b1};
        alu_tab[2]  = '{enc(7'h20, 3'b000, 7'h33), 32'h3,        32'h5,        32'hFFFFFFFE, 1'b1};
        alu_tab[3]  = '{enc(7'h00, 3'b011, 7'h33), 32'h1,        32'hFFFFFFFF, 32'h1,        1'b1};
        alu_tab[4]  = '{enc(7'h00, 3'b010, 7'h33), 32'hFFFFFFFF, 32'h1,        32'h1,        1'b1};
        alu_tab[5]  = '{enc(7'h00, 3'b001, 7'h33), 32'h1,        32'h24,       32'h10,       1'b1};
        alu_tab[6]  = '{enc(7'h00, 3'b101, 7'h33), 32'h80000000, 32'h4,        32'h08000000, 1'b1};
        alu_tab[7]  = '{enc(7'h00, 3'b100, 7'h33), 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b1};
        alu_tab[8]  = '{enc(7'h00, 3'b110, 7'h13), 32'hF0F0F0F0, 32'h0F000000, 32'hFFF0F0F0, 1'b1};
        alu_tab[9]  = '{enc(7'h00, 3'b111, 7'h33), 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b1};
        alu_tab[10] = '{enc(7'h12, 3'b111, 7'h37), 32'h0,        32'h12345000, 32'h12345000, 1'b1};
        alu_tab[11] = '{enc(7'h00, 3'b000, 7'h33), 32'hFFFFFFFF, 32'h1,        32'h0,        1'b1};
        alu_tab[12] = '{enc(7'h00, 3'b000, 7'h03), 32'h7,        32'h9,        32'h0,        1'b0};
        alu_tab[13] = '{enc(7'h20, 3'b101, 7'h13), 32'h80000010, 32'h1,        32'hC0000008, 1'b1};

        m_tab[0]  = '{"MUL -3*7",   enc(7'h01, 3'b000, 7'h33), 32'hFFFFFFFD, 32'h7,        32'hFFFFFFEB};
        m_tab[1]  = '{"MULHU",      enc(7'h01, 3'b011, 7'h33), 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
        m_tab[2]  = '{"MULH min2",  enc(7'h01, 3'b001, 7'h33), 32'h80000000, 32'h80000000, 32'h40000000};
        m_tab[3]  = '{"MULHSU",     enc(7'h01, 3'b010, 7'h33), 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        m_tab[4]  = '{"DIVU 7/0",   enc(7'h01, 3'b101, 7'h33), 32'h7,        32'h0,        32'hFFFFFFFF};
        m_tab[5]  = '{"REM 7/0",    enc(7'h01, 3'b110, 7'h33), 32'h7,        32'h0,        32'h7};
        m_tab[6]  = '{"DIV ovf",    enc(7'h01, 3'b100, 7'h33), 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
        m_tab[7]  = '{"REM -7/2",   enc(7'h01, 3'b110, 7'h33), 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF};
        m_tab[8]  = '{"DIV -7/2",   enc(7'h01, 3'b100, 7'h33), 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD};
        m_tab[9]  = '{"REMU 100/7", enc(7'h01, 3'b111, 7'h33), 32'd100,      32'd7,        32'h2};
        m_tab[10] = '{"DIV -7/0",   enc(7'h01, 3'b100, 7'h33), 32'hFFFFFFF9, 32'h0,        32'hFFFFFFFF};
        m_tab[11] = '{"REM ovf",    enc(7'h01, 3'b110, 7'h33), 32'h80000000, 32'hFFFFFFFF, 32'h0};

        rst       = 1'b1;
        flush     = 1'b0;
        reg_we    = 1'b1;
        reg_waddr = 5'd9;
        inst_addr = 32'h0000_1000;
        inst      = enc(7'h00, 3'b000, 7'h33);
        op1       = 32'h1;
        op2       = 32'h2;
        #2;
        check("reset outputs", {26'd0, reg_wdata_o, reg_we_o, reg_waddr_o},
              {26'd0, 32'h0, 1'b0, 5'd0});
        check("reset addr/hold", {31'd0, inst_addr_o, hold_o}, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            apply(alu_tab[i].inst, alu_tab[i].op1, alu_tab[i].op2);
            reg_waddr = 5'(i + 1);
            inst_addr = 32'h1000 + 32'(4 * i);
            exp_q.push_back('{alu_tab[i].wdata, alu_tab[i].we, 1'b0});
            @(negedge clk);
            check_out($sformatf("alu[%0d]", i));
            check($sformatf("alu[%0d] waddr", i), 64'(reg_waddr_o), 64'(i + 1));
        end
        check("inst_addr pass", 64'(inst_addr_o), 64'h1034);

        for (int i = 0; i < 12; i++) run_m(m_tab[i]);

        // DIV in flight, flush at T+10, then a plain ADD
        apply(enc(7'h01, 3'b100, 7'h33), 32'd100, 32'd7);
        hcnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (hold_o) hcnt++;
        end
        check("flush pre-hold", 64'(hcnt), 64'd10);
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(negedge clk);
        check("flush cycle", {62'd0, hold_o, reg_we_o}, 64'd0);
        apply(enc(7'h00, 3'b000, 7'h33), 32'd20, 32'd22);
        flush = 1'b0;
        exp_q.push_back('{32'd42, 1'b1, 1'b0});
        exp_q.push_back('{32'd42, 1'b1, 1'b0});
        @(negedge clk);
        check_out("add after flush");
        @(negedge clk);
        check_out("add after flush +1");

        // Async reset in the middle of a MUL
        apply(enc(7'h01, 3'b000, 7'h33), 32'hFFFFFFFD, 32'h7);
        repeat (15) @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("mid-op reset", {26'd0, reg_wdata_o, reg_we_o, reg_waddr_o}, 64'd0);
        check("mid-op reset hold", {31'd0, inst_addr_o, hold_o}, 64'd0);
        @(posedge clk);
        #1;
        inst = enc(7'h00, 3'b000, 7'h33);
        op1  = 32'd1;
        op2  = 32'd1;
        #1;
        rst = 1'b0;
        #1;
        exp_q.push_back('{32'd2, 1'b1, 1'b0});
        exp_q.push_back('{32'd2, 1'b1, 1'b0});
        check_out("add after reset");
        @(negedge clk);
        @(negedge clk);
        check_out("add after reset +1");

        run_m(m_tab[0]);
        check("scoreboard drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
